// File: rtl/usb_rx_phy_pkg.sv
// Shared types, constants and line decoding for the USB receive front end.
package usb_rx_phy_pkg;

    // Raw {D+,D-} pin pair.
    typedef logic [1:0] d_port_t;

    // Decoded line condition of the synchronised pin pair.
    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10,
        SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        ERROR
    } rx_state_t;

    // Minimum run of decoded zeros before the closing 1 of SYNC is accepted.
    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd5;
    // After this many consecutive ones the next bit must be a stuffed zero.
    localparam logic [2:0] MAX_ONES       = 3'd6;
    // Counter value on the last J strobe of the 8-J recovery run in ERROR.
    localparam logic [2:0] ERR_J_LAST     = 3'd7;
    // Bit index of the last bit in a byte.
    localparam logic [2:0] BYTE_LAST      = 3'd7;

    // Map the pin pair to SE0/J/K/SE1; J polarity depends on bus speed.
    function automatic line_state_t decode_line(input d_port_t pins, input logic low_speed);
        line_state_t ls;
        case (pins)
            2'b00:   ls = SE0;
            2'b11:   ls = SE1;
            default: ls = ((pins == 2'b01) == low_speed) ? J : K;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_rx_phy_dpll.sv
// Input synchroniser and bit-timing recovery: a free-running phase counter
// that is re-zeroed on every J<->K transition and strobes at mid-bit.
module usb_rx_dpll #(
    parameter int SPB = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] line,
    output logic       strobe,
    output logic [1:0] sampled
);

    localparam int            PW         = $clog2(SPB);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SPB - 1);
    localparam logic [PW-1:0] PHASE_MID  = PW'(SPB / 2 - 1);

    logic [1:0]    sync1_q, sync2_q, sync3_q;
    logic [PW-1:0] phase_q, phase_d;
    logic          jk_edge;

    // A J<->K change flips both pins; transitions through SE0/SE1 do not retime.
    assign jk_edge = (sync2_q != sync3_q)
                   && (sync2_q[1] ^ sync2_q[0])
                   && (sync3_q[1] ^ sync3_q[0]);

    // Phase counter: restart on a data edge, otherwise count and wrap each bit.
    always_comb begin
        phase_d = phase_q + 1'b1;
        if (jk_edge || phase_q == PHASE_LAST) begin
            phase_d = '0;
        end
    end

    // Two-flop synchroniser, edge-detect flop and phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            sync3_q <= 2'b00;
            phase_q <= '0;
        end else begin
            sync1_q <= line;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            phase_q <= phase_d;
        end
    end

    // The edge cycle itself never strobes, so a retime cannot double-sample.
    assign strobe  = (phase_q == PHASE_MID) && !jk_edge;
    assign sampled = sync2_q;

endmodule

// File: rtl/usb_rx_phy.sv
// USB low/full-speed receive PHY: NRZI decode, bit unstuffing, SYNC/EOP
// framing, byte assembly and bus-reset timing on top of the DPLL.
module usb_rx_phy
    import usb_rx_phy_pkg::*;
#(
    parameter int SPB          = 16,
    parameter bit LOW_SPEED    = 1'b1,
    parameter int RESET_CYCLES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] d_i,
    input  logic       tx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error,
    output logic [1:0] line_state,
    output logic       bus_reset
);

    localparam int            RW      = $clog2(RESET_CYCLES + 1);
    localparam logic [RW-1:0] SE0_MAX = RW'(RESET_CYCLES);

    logic        strobe;
    logic [1:0]  sampled;
    line_state_t line_ls;
    logic        nrzi_one;

    rx_state_t   state_q, state_d;
    line_state_t prev_q, prev_d;
    // Shared run counter: zeros in SYNC, ones in DATA, J strobes in ERROR.
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic [RW-1:0] se0_cnt_q;

    usb_rx_dpll #(.SPB(SPB)) u_dpll (
        .clk     (clk),
        .reset   (reset),
        .line    (d_i),
        .strobe  (strobe),
        .sampled (sampled)
    );

    assign line_ls  = decode_line(sampled, LOW_SPEED);
    assign nrzi_one = (line_ls == prev_q);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_q    <= SE0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    // Next-state logic, evaluated once per recovered bit strobe.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        if (strobe) begin
            prev_d = line_ls;
        end
        if (tx_en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
        end else if (strobe) begin
            case (state_q)
                IDLE: begin
                    // The J->K edge is itself the first SYNC zero.
                    if (line_ls == K && prev_q == J) begin
                        state_d = SYNC;
                        cnt_d   = 3'd1;
                    end
                end
                SYNC: begin
                    if (line_ls == SE0 || line_ls == SE1) begin
                        state_d = IDLE;
                    end else if (!nrzi_one) begin
                        if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
                    end else if (cnt_q >= SYNC_MIN_ZEROS) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (line_ls == SE0) begin
                        state_d = EOP;
                    end else if (line_ls == SE1) begin
                        error_d = 1'b1;
                        state_d = ERROR;
                        cnt_d   = '0;
                    end else if (cnt_q == MAX_ONES) begin
                        // Stuff slot: a zero is discarded, a one is a violation.
                        if (nrzi_one) begin
                            error_d = 1'b1;
                            state_d = ERROR;
                        end
                        cnt_d = '0;
                    end else begin
                        cnt_d   = nrzi_one ? cnt_q + 3'd1 : 3'd0;
                        shift_d = {nrzi_one, shift_q[7:1]};
                        if (bit_cnt_q == BYTE_LAST) begin
                            data_d    = shift_d;
                            valid_d   = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                EOP: begin
                    // Any partial byte is dribble and simply dropped here.
                    if (line_ls == J) begin
                        state_d = IDLE;
                    end else if (line_ls != SE0) begin
                        error_d = 1'b1;
                        state_d = ERROR;
                        cnt_d   = '0;
                    end
                end
                ERROR: begin
                    if (line_ls == J) begin
                        if (prev_q == SE0 || cnt_q == ERR_J_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: packet-active flag derived from state, strobes from registers.
    always_comb begin
        rx_active  = !tx_en && (state_q == DATA || state_q == EOP);
        rx_data    = data_q;
        rx_valid   = valid_q;
        rx_error   = error_q;
        line_state = line_ls;
        bus_reset  = (se0_cnt_q == SE0_MAX);
    end

    // SE0 duration timer: saturating, cleared by any non-SE0 cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            se0_cnt_q <= '0;
        end else if (line_ls != SE0) begin
            se0_cnt_q <= '0;
        end else if (se0_cnt_q != SE0_MAX) begin
            se0_cnt_q <= se0_cnt_q + 1'b1;
        end
    end

endmodule
